// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared state encoding and constants for the regfile_np family
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_ZERO_ADDR = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_bypass_sel.sv
`default_nettype none
// ============================================================================
// rf_bypass_sel : per-read-port forwarding mux, highest write port index wins
// Revision      : 1.0
// ============================================================================
module rf_bypass_sel #(
  parameter int NUM_WR = 2,
  parameter int WIDTH  = 32,
  parameter int AW     = 5
) (
  input  logic [NUM_WR-1:0]       we_i,
  input  logic [NUM_WR*AW-1:0]    wa_i,
  input  logic [NUM_WR*WIDTH-1:0] wd_i,
  input  logic [AW-1:0]           ra_i,
  input  logic [WIDTH-1:0]        rf_data_i,
  output logic [WIDTH-1:0]        rd_o
);

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    rd_o = rf_data_i;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we_i[i] && (wa_i[i*AW +: AW] == ra_i)) begin
        rd_o = wd_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule : rf_bypass_sel
`default_nettype wire

// File: rtl/regfile_np.sv
`default_nettype none
// ============================================================================
// regfile_np : multi-port register file with bypass, write-conflict flag and
//              post-reset clear sweep; register 0 reads as zero
// Revision   : 1.0
// ============================================================================
module regfile_np
  import regfile_pkg::*;
#(
  parameter int NUM_REG = 32,
  parameter int WIDTH   = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(NUM_REG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    wa,
  input  logic [NUM_WR*WIDTH-1:0] wd,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  output logic                    ready,
  output logic                    wr_conflict
);

  rf_state_t        state_q;
  logic [AW-1:0]    ptr_q;
  logic             ready_q;
  logic             wr_conflict_q;
  logic [WIDTH-1:0] rf_q [NUM_REG];

  logic              run;
  logic [NUM_WR-1:0] we_eff;
  logic [NUM_WR-1:0] byp_we;
  logic              conflict_d;

  assign run = (state_q == RF_RUN);

  // A write is effective only in RUN and only to a nonzero address.
  always_comb begin
    we_eff = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      we_eff[i] = we[i] && run && (wa[i*AW +: AW] != AW'(RF_ZERO_ADDR));
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (we_eff[i] && we_eff[j] && (wa[i*AW +: AW] == wa[j*AW +: AW])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RF_CLEAR;
      ptr_q         <= AW'(1);
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= conflict_d;
      case (state_q)
        RF_CLEAR: begin
          // Pointer parks on the last entry rather than wrapping.
          if (ptr_q == AW'(NUM_REG - 1)) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        RF_RUN: begin
          state_q <= RF_RUN;
        end
        default: begin
          state_q <= RF_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == RF_CLEAR) begin
        rf_q[ptr_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we_eff[i]) begin
            rf_q[wa[i*AW +: AW]] <= wd[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign byp_we = (BYPASS != 0) ? we_eff : '0;

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [AW-1:0]    ra_j;
      logic [WIDTH-1:0] sel_j;

      assign ra_j = ra[j*AW +: AW];

      rf_bypass_sel #(
        .NUM_WR (NUM_WR),
        .WIDTH  (WIDTH),
        .AW     (AW)
      ) u_sel (
        .we_i      (byp_we),
        .wa_i      (wa),
        .wd_i      (wd),
        .ra_i      (ra_j),
        .rf_data_i (rf_q[ra_j]),
        .rd_o      (sel_j)
      );

      assign rd[j*WIDTH +: WIDTH] =
        (run && (ra_j != AW'(RF_ZERO_ADDR))) ? sel_j : '0;
    end
  endgenerate

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

endmodule : regfile_np
`default_nettype wire

// File: doc/regfile_np.md
Name: regfile_np

Overview:
- Parametrised multi-port register file; next generation of the 2-read/1-write processor register file.
- Configurable read and write port counts, optional write-to-read bypass, detection of write conflicts between ports, and a hardware clear sequencer after reset.
- Sits in the datapath decode stage of the wider-issue MIPS core.
- Register 0 is hardwired to zero.

Parameters:
- NUM_REG, 32, number of registers; power of 2, >= 4.
- WIDTH, 32, data width in bits.
- NUM_RD, 2, number of read ports; >= 1.
- NUM_WR, 2, number of write ports; >= 1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the stored value only.
- AW (derived, localparam), $clog2(NUM_REG), address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- we  input  NUM_WR  per-port write enable; bit i belongs to port i.
- wa  input  NUM_WR*AW  write addresses; port i occupies [i*AW +: AW].
- wd  input  NUM_WR*WIDTH  write data; port i occupies [i*WIDTH +: WIDTH].
- ra  input  NUM_RD*AW  read addresses; port j occupies [j*AW +: AW].
- rd  output  NUM_RD*WIDTH  read data, combinational; port j occupies [j*WIDTH +: WIDTH].
- ready  output  1  high once the clear sweep is complete.
- wr_conflict  output  1  registered one-cycle pulse flagging a multi-port write to the same address.

Behaviour:
- State machine, states CLEAR and RUN.
  - reset high at a posedge: state <= CLEAR, clear pointer <= 1, ready <= 0, wr_conflict <= 0.
  - Storage contents are not reset directly.
- CLEAR sweep:
  - Each posedge with reset low: rf[ptr] <= 0, then ptr <= ptr+1.
  - At the posedge that clears NUM_REG-1, state <= RUN and ready <= 1.
  - ready therefore rises exactly NUM_REG-1 posedges after the first posedge with reset low.
- Behaviour while in CLEAR:
  - All external writes are ignored.
  - All rd outputs read 0.
  - wr_conflict stays 0.
- Reset mid-sweep or during RUN: returns to CLEAR with ptr=1; the full sweep restarts.
- Writes in RUN:
  - For each port i with we[i]=1 and wa_i != 0: rf[wa_i] <= wd_i at the posedge.
  - Writes to address 0 are discarded.
- Same-address priority: if several enabled ports target the same nonzero address, the highest port index wins.
- wr_conflict:
  - Registered. wr_conflict <= 1 at the posedge following any cycle in RUN where two or more enabled ports share a nonzero address; otherwise 0.
  - Address-0 collisions are not conflicts.
- Reads:
  - Combinational.
  - ra_j == 0 gives 0 in every state.
  - BYPASS=1, state RUN: if any enabled write port targets ra_j (nonzero), rd_j = wd of the highest-index matching port; otherwise rf[ra_j].
  - BYPASS=0: rd_j = rf[ra_j]; the new value is visible the cycle after the write.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Width rules: no arithmetic on data; the clear pointer is AW bits wide and does not wrap past NUM_REG-1.

Decomposition:
- Shared package regfile_pkg:
  - enum rf_state_t {RF_CLEAR, RF_RUN}.
  - Constant RF_ZERO_ADDR = 0.
- One sub-module rf_bypass_sel: per-read-port forwarding priority mux, parameterised on NUM_WR, WIDTH and AW; instantiated NUM_RD times with a generate loop.
- Conflict detector and clear FSM live in regfile_np.

Test Plan:
- Clear sweep: preload registers with 0xFFFF_FFFF, pulse reset for 2 cycles, hold reset low -> ready=0 for 31 posedges and 1 after the 31st; every register then reads 0; rd stays 0 during the sweep even with we=2'b11.
- Basic write and bypass, BYPASS=1, RUN: port0 writes 0x1234_5678 to r5, ra0=5 in the same cycle -> rd0=0x1234_5678 combinationally; after the edge with we=0, rd0=0x1234_5678. With BYPASS=0 -> rd0 shows the old value 0, then 0x1234_5678 after the edge.
- Conflict: port0 writes 0xAAAA_AAAA and port1 writes 0x5555_5555, both to r7 -> r7=0x5555_5555; wr_conflict=1 for exactly one cycle after the edge; same-cycle bypass read of r7 = 0x5555_5555.
- Register zero: both ports write 0xDEAD_BEEF to r0 -> rd=0 for ra=0; wr_conflict stays 0.
- Reset mid-sweep: assert reset at sweep cycle 10 -> ready stays 0; ready rises exactly 31 posedges after reset deasserts; r20, written before the reset, reads 0.
- Parameter sweep: NUM_RD=4, NUM_WR=1, NUM_REG=8 -> ready after 7 cycles; 4 simultaneous reads of r1..r4 return the values written 0x11, 0x22, 0x33, 0x44.
